// File: rtl/decode_issue_stage.sv
// decode_issue_stage: RV32I decode, register read and immediate generation into the ID/EX register.
// Optional DECODE_ILLEGAL_TRAP_EN adds an illegal output that flags unsupported encodings.
module decode_issue_stage #(
  parameter int XLEN = 32,
  parameter int LOAD_STALL = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall,
  output logic [11:0]     operation,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] imm,
  output logic [1:0]      need_forward,
  output logic [XLEN-1:0] pc,
  output logic [4:0]      rd_addr,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
`ifdef DECODE_ILLEGAL_TRAP_EN
  output logic            illegal,
`endif
  output logic            valid
);
  localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
  logic [XLEN-1:0] rf [32];
  logic [1:0] cnt;
  logic [6:0] opc;
  logic [2:0] f3;
  logic [4:0] ra, rb;
  logic is_op, is_opi, is_ld, is_st, is_br, is_jal, is_jalr, is_shift;
  logic use_a, use_b, fwd_ok, hazard, issue, iss, ill;
  logic [1:0] op_hi;
  logic [XLEN-1:0] rd_a, rd_b, imm_d;
  assign opc = instr[6:0];
  assign f3 = instr[14:12];
  assign ra = instr[19:15];
  assign rb = instr[24:20];
  assign is_op = opc == OP;
  assign is_opi = opc == OPI;
  assign is_ld = opc == LD;
  assign is_st = opc == ST;
  assign is_br = opc == BR;
  assign is_jal = opc == JAL;
  assign is_jalr = opc == JALR;
  assign is_shift = is_opi && f3[1:0] == 2'b01;
  assign use_a = is_op || is_opi || is_ld || is_st || is_br || is_jalr;
  assign use_b = is_op || is_br;
  // write-through so a same-cycle writeback is seen by the decoding instruction
  assign rd_a = ra == 5'd0 ? '0 : (wb_en && wb_addr == ra) ? wb_data : rf[ra];
  assign rd_b = rb == 5'd0 ? '0 : (wb_en && wb_addr == rb) ? wb_data : rf[rb];
  assign op_hi = {is_op && instr[30], is_opi && f3 == 3'b101 && instr[30]};
  assign imm_d = is_shift ? {{(XLEN-5){1'b0}}, instr[24:20]} :
                 (is_opi || is_ld || is_jalr) ? {{(XLEN-12){instr[31]}}, instr[31:20]} :
                 is_st ? {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]} :
                 is_br ? {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
                 is_jal ? {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0} : '0;
  assign fwd_ok = valid && reg_write && rd_addr != 5'd0 && !mem_read;
  assign hazard = instr_valid && valid && mem_read && rd_addr != 5'd0 &&
                  ((use_a && ra == rd_addr) || (use_b && rb == rd_addr));
  assign stall = hazard || cnt != 2'd0;
  assign issue = !flush && !stall && instr_valid;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic bad;
  assign bad = !(is_op || is_opi || is_ld || is_st || is_br || is_jal || is_jalr) ||
               (is_op && instr[31:25] != 7'b0000000 && instr[31:25] != 7'b0100000);
  assign iss = issue && !bad;
  assign ill = issue && bad;
`else
  assign iss = issue;
  assign ill = 1'b0;
`endif
  always_ff @(posedge clk)
    if (wb_en && wb_addr != 5'd0) rf[wb_addr] <= wb_data;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 2'd0;
      operation <= '0;
      rs1 <= '0;
      rs2 <= '0;
      imm <= '0;
      need_forward <= 2'b00;
      pc <= '0;
      rd_addr <= 5'd0;
      reg_write <= 1'b0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      valid <= 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      illegal <= 1'b0;
`endif
    end else begin
      cnt <= flush ? 2'd0 : hazard ? 2'(LOAD_STALL - 1) : cnt != 2'd0 ? cnt - 2'd1 : 2'd0;
      operation <= iss ? {op_hi, f3, opc} : '0;
      rs1 <= iss ? rd_a : '0;
      rs2 <= iss ? rd_b : '0;
      imm <= iss ? imm_d : '0;
      need_forward <= iss ? {fwd_ok && use_a && ra == rd_addr, fwd_ok && use_b && rb == rd_addr} : 2'b00;
      pc <= (iss || ill) ? pc_in : '0;
      rd_addr <= iss ? instr[11:7] : 5'd0;
      reg_write <= iss && (is_op || is_opi || is_ld || is_jal || is_jalr);
      mem_read <= iss && is_ld;
      mem_write <= iss && is_st;
      valid <= iss;
`ifdef DECODE_ILLEGAL_TRAP_EN
      illegal <= ill;
`endif
    end
  end
endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- ID/EX stage directly upstream of the ALU: decodes a 32-bit RV32I instruction, reads the 32x32 register file and generates the immediate.
- Builds the 12-bit ALU operation code and the need_forward select.
- Drives all ALU operands from a registered ID/EX boundary.
- Detects load-use hazards, stalls fetch and inserts bubbles; accepts flushes from branch/jump resolution.

Parameters:
XLEN, 32, datapath width
LOAD_STALL, 2, bubbles inserted on a load-use hazard (1..3)

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  asynchronous, active-low reset
instr_valid  in  1  fetch presents a valid instruction
instr  in  32  instruction word
pc_in  in  XLEN  pc of instr
flush  in  1  kill the instruction in decode and the one in the output register
wb_en  in  1  register file write enable
wb_addr  in  5  write index
wb_data  in  XLEN  write data
stall  out  1  combinational; fetch must hold instr/pc_in while high
operation  out  12  {op_hi[1:0], funct3, opcode} to ALU
rs1  out  XLEN  register operand 1
rs2  out  XLEN  register operand 2
imm  out  XLEN  sign-extended immediate
need_forward  out  2  00 none, 01 rs2, 10 rs1, 11 both
pc  out  XLEN  pc of issued instruction
rd_addr  out  5  destination index
reg_write  out  1  instruction writes rd
mem_read  out  1  load issued
mem_write  out  1  store issued
valid  out  1  output register holds a real instruction

Behaviour:
- Reset (reset=0, async): every output register is 0 (operation=12'h000 = bubble, valid=0); stall counter is 0; register file contents are not reset. x0 always reads 0 and writes to it are dropped.
- Operation code:
  - op_hi[1] = instr[30] for opcode 0110011 only.
  - op_hi[0] = instr[30] for opcode 0010011 with funct3=101 only.
  - op_hi = 00 otherwise.
  - The code then carries funct3 = instr[14:12] and opcode = instr[6:0].
- Immediates:
  - I: loads, OP-IMM, JALR.
  - S: stores.
  - B: branches, bit 0 forced 0.
  - J: JAL.
  - Shift-immediate: imm = zero-extended shamt instr[24:20].
  - R-type: imm = 0.
- Register read: combinational from the array, with write-through bypass. If wb_en and wb_addr==index!=0, the read returns wb_data in the same cycle.
- Forwarding: set need_forward[1] (rs1) / need_forward[0] (rs2) when all of the following hold:
  - the output register is valid with reg_write=1 and rd_addr!=0;
  - it is not a load;
  - its rd_addr equals the decoded source index;
  - the source is actually used (rs2 only for opcodes 0110011/1100011).
- Hazards at distance >= 2 are covered by the register file bypass. Writeback is required to present the ALU result on the wb port on the cycle after the ALU registers it.
- Load-use hazard: the output register holds a valid load (mem_read=1, rd_addr!=0) whose rd_addr matches a used source.
  - stall=1, the counter loads LOAD_STALL-1, and a bubble is issued.
  - stall stays high while counter!=0; the counter decrements each cycle.
  - The instruction issues on the cycle the counter reaches 0.
- Issue: on each posedge with stall=0, the output register captures the decoded instruction if instr_valid=1, else a bubble.
- Bubble: operation=0, valid=0, reg_write=mem_read=mem_write=0, rd_addr=0, need_forward=00.
- Flush: next posedge writes a bubble, clears the stall counter and drops stall. Flush takes priority over stall and issue.
- Simultaneous wb write and decode read of the same register: the new value is used.
- Control flags:
  - reg_write=1 for opcodes 0110011, 0010011, 0000011, 1101111, 1100111.
  - mem_write=1 for 0100011.
  - Branches and stores have reg_write=0.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- When defined:
  - Adds output illegal (1 bit, reset 0), registered with the other outputs.
  - illegal is set for an unsupported opcode, or an OP funct7 not in {0000000,0100000}.
  - An illegal instruction issues as a bubble but with illegal=1 and pc valid.
- When undefined:
  - No illegal port.
  - Unsupported opcodes issue with valid=1, reg_write=0 and the raw operation code.

Test Plan:
- Reset mid-run: assert reset=0 asynchronously between edges -> all outputs 0 immediately, stall=0.
- Back-to-back dependency: addi x1,x0,5 then add x2,x1,x1 -> second issue has need_forward=11, operation=12'b000000110011, no stall.
- Load-use: lw x3,0(x1) then sub x4,x3,x2 (LOAD_STALL=2) -> stall high 2 cycles, 2 bubbles, sub issues with need_forward=00 and operation=12'b100000110011.
- Bypass: wb_en=1, wb_addr=5, wb_data=0xDEADBEEF while decoding or x6,x5,x0 -> rs1=0xDEADBEEF.
- Immediates: srai x1,x2,3 -> operation=12'b011010010011, imm=3. beq with offset -8 -> imm=0xFFFFFFF8.
- Flush during load stall -> next edge bubble, stall=0, the stalled instruction is discarded.
